sint_diver: RTL and testbench
=============================

# sint_diver

Parametrised iterative integer divider with a start/busy/done handshake. It computes signed or unsigned quotient and remainder of two WIDTH-bit operands using one restoring-division step per clock. It is the execute-stage divide unit of the pipeline CPU, driven by the DIV/DIVU/REM/REMU decode path, and generalises the fixed 32-bit unsigned divider. It adds a signed mode, a parametrised width, explicit divide-by-zero and overflow handling, and a synchronous reset.

## Interface
- WIDTH, 32, operand/result width in bits (≥4); iteration counter width is $clog2(WIDTH+1)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  request; sampled only in IDLE
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; latched with start
- dividend  in  WIDTH  numerator; latched with start
- divisor  in  WIDTH  denominator; latched with start
- busy  out  1  high while a division is in progress (CALC or FIX)
- done  out  1  one-cycle pulse; quotient/remainder/div_zero valid in that cycle
- quotient  out  WIDTH  registered quotient; holds until the next done
- remainder  out  WIDTH  registered remainder; holds until the next done
- div_zero  out  1  registered; set with done when the latched divisor was 0

## Operation
- States: IDLE, CALC, FIX.
- IDLE + start: latch is_signed, the operand signs, |dividend| (if signed and negative, else raw) and |divisor| into W-bit magnitude registers. Clear the partial remainder, load the counter with WIDTH, go to CALC.
- IDLE without start: stay in IDLE.
- CALC, each cycle:
  - shift {partial_rem, quot_shift} left 1.
  - Compute trial = partial_rem_shifted − divisor_mag using a (WIDTH+1)-bit subtract.
  - If there is no borrow, partial_rem ← trial and shift in 1; otherwise shift in 0.
  - Decrement the counter. When the counter reaches 1 before the update, go to FIX.
- FIX (one cycle), then return to IDLE:
  - q = quot_shift, negated if signed and the signs differ.
  - r = partial_rem, negated if signed and the dividend is negative.
  - Register quotient and remainder, assert done.
- Magnitudes are unsigned WIDTH bits. The most negative value (MIN = 1 followed by WIDTH−1 zeros) has magnitude 2^(WIDTH−1), which is representable, so no extra bit is needed.
- Divisor = 0: no special path in CALC. FIX forces quotient = all ones, remainder = the original latched dividend and div_zero = 1, for both modes.
- Signed MIN / −1: the natural result applies, quotient = MIN and remainder = 0, with div_zero = 0. The bench checks this explicitly.
- start while busy: ignored, and the operand inputs are not sampled.
- start in the same cycle as done: accepted, because the state is already IDLE.
- Reset: rst_n low at a rising edge forces state IDLE, busy 0, done 0, quotient 0, remainder 0, div_zero 0 and counter 0. Reset mid-operation aborts the division and no done pulse is produced.

## Timing
- start high in cycle 0 (IDLE):
  - busy is high in cycles 1..WIDTH+1 (CALC for WIDTH cycles, FIX in cycle WIDTH+1).
  - done is high only in cycle WIDTH+2, when busy is 0.
  - Latency is fixed at WIDTH+2 cycles, independent of operands and mode (34 for WIDTH=32).
- busy is a registered state decode and never glitches high outside CALC/FIX.
- done is registered and lasts exactly one cycle. quotient, remainder and div_zero change only on the edge that raises done.
- Back-to-back throughput is one result per WIDTH+2 cycles when start is held high continuously.

## Test plan
- WIDTH=32, unsigned, 100 / 7, start in cycle 0 → done in cycle 34 only, quotient = 14, remainder = 2, div_zero = 0; busy high in cycles 1..33.
- Signed −7 / 2 (0xFFFFFFF9 / 0x2) → quotient = 0xFFFFFFFD (−3), remainder = 0xFFFFFFFF (−1). Signed 7 / −2 → quotient = 0xFFFFFFFD, remainder = 1. Unsigned 0xFFFFFFF9 / 2 → quotient = 0x7FFFFFFC, remainder = 1.
- Divide by zero: unsigned 0x1234 / 0 and signed −5 / 0 → quotient = 0xFFFFFFFF, remainder = dividend, div_zero = 1, same 34-cycle latency.
- Signed 0x80000000 / 0xFFFFFFFF → quotient = 0x80000000, remainder = 0, div_zero = 0.
- Handshake:
  - start pulsed again in cycles 5 and 20 with different operands → ignored, and the result matches the first operands.
  - start held high through the done cycle → the second division is accepted; the next done arrives 34 cycles later with the new operands' result.
- Reset mid-operation: rst_n low in cycle 10 for one cycle → from cycle 11, busy = 0, done = 0, quotient = 0, remainder = 0, and no done appears. A new start then completes normally in 34 cycles.

Source files
------------

// File: rtl/sint_diver.sv
// sint_diver: iterative signed/unsigned integer divider.
// One restoring-division step per clock, start/busy/done handshake.
module sint_diver #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             sgn_q;
    logic             neg_dvd_q;
    logic             neg_dvs_q;
    logic [WIDTH-1:0] dvd_raw_q;
    logic [WIDTH-1:0] dvs_mag_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             div_zero_q;

    logic [WIDTH-1:0] dvd_mag_d;
    logic [WIDTH-1:0] dvs_mag_d;
    logic [WIDTH:0]   shifted_d;
    logic [WIDTH:0]   trial_d;
    logic [WIDTH-1:0] q_fix_d;
    logic [WIDTH-1:0] r_fix_d;

    // Operand magnitudes, restoring step and sign fix-up values.
    always_comb begin
        dvd_mag_d = dividend;
        dvs_mag_d = divisor;
        if (is_signed && dividend[WIDTH-1]) dvd_mag_d = -dividend;
        if (is_signed && divisor[WIDTH-1])  dvs_mag_d = -divisor;
        shifted_d = {rem_q, quo_q[WIDTH-1]};
        trial_d   = shifted_d - {1'b0, dvs_mag_q};
        q_fix_d   = (neg_dvd_q ^ neg_dvs_q) ? -quo_q : quo_q;
        r_fix_d   = neg_dvd_q ? -rem_q : rem_q;
    end

    // Control FSM, datapath registers and registered results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sgn_q       <= 1'b0;
            neg_dvd_q   <= 1'b0;
            neg_dvs_q   <= 1'b0;
            dvd_raw_q   <= '0;
            dvs_mag_q   <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        sgn_q     <= is_signed;
                        neg_dvd_q <= is_signed & dividend[WIDTH-1];
                        neg_dvs_q <= is_signed & divisor[WIDTH-1];
                        dvd_raw_q <= dividend;
                        dvs_mag_q <= dvs_mag_d;
                        quo_q     <= dvd_mag_d;
                        rem_q     <= '0;
                        cnt_q     <= CW'(WIDTH);
                        state_q   <= CALC;
                    end
                end
                CALC: begin
                    if (!trial_d[WIDTH]) begin
                        rem_q <= trial_d[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_q <= shifted_d[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_q <= FIX;
                end
                FIX: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                    if (dvs_mag_q == '0) begin
                        quotient_q  <= '1;
                        remainder_q <= dvd_raw_q;
                        div_zero_q  <= 1'b1;
                    end else begin
                        quotient_q  <= q_fix_d;
                        remainder_q <= r_fix_d;
                        div_zero_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = (state_q == CALC) || (state_q == FIX);
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_sint_diver.sv
// tb_sint_diver: directed-vector bench for sint_diver (WIDTH=32).
// Outputs are sampled on the falling clock edge.
module tb_sint_diver;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;

    int errs;
    int checks;

    sint_diver #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Count cycles until done; optionally pokes start in cycles 5 and 20.
    task automatic wait_done(input bit poke, output int n,
                             output logic b1, output logic b33,
                             output logic bd);
        n = 0;
        b1 = 1'b0;
        b33 = 1'b0;
        bd = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (n == 1)  b1 = busy;
            if (n == 33) b33 = busy;
            if (poke) begin
                start = (n == 5) || (n == 20);
                if (start) begin
                    is_signed = 1'b0;
                    dividend  = 32'd999;
                    divisor   = 32'd3;
                end
            end
        end while (!done && n < 60);
        bd = busy;
    endtask

    task automatic check_result(input string tag, input int n,
                                input logic b1, input logic b33,
                                input logic bd, input logic [31:0] eq,
                                input logic [31:0] er, input logic ez);
        chk({tag, ".lat"}, 32'(n), 32'd34);
        chk({tag, ".busy1"}, {31'd0, b1}, 32'd1);
        chk({tag, ".busy33"}, {31'd0, b33}, 32'd1);
        chk({tag, ".busydone"}, {31'd0, bd}, 32'd0);
        chk({tag, ".q"}, quotient, eq);
        chk({tag, ".r"}, remainder, er);
        chk({tag, ".dz"}, {31'd0, div_zero}, {31'd0, ez});
    endtask

    task automatic div_case(input string tag, input logic sgn,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] eq, input logic [31:0] er,
                            input logic ez, input bit poke);
        int   n;
        logic b1, b33, bd;
        @(negedge clk);
        start     = 1'b1;
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(poke, n, b1, b33, bd);
        check_result(tag, n, b1, b33, bd, eq, er, ez);
        start = 1'b0;
    endtask

    initial begin
        int   n;
        int   dcnt;
        logic b1, b33, bd;
        errs      = 0;
        checks    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        chk("rst.q", quotient, 32'd0);
        chk("rst.r", remainder, 32'd0);
        chk("rst.dz", {31'd0, div_zero}, 32'd0);
        rst_n = 1'b1;

        div_case("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0);
        div_case("s-7_2", 1'b1, 32'hFFFFFFF9, 32'd2,
                 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 0);
        div_case("s7_-2", 1'b1, 32'd7, 32'hFFFFFFFE,
                 32'hFFFFFFFD, 32'd1, 1'b0, 0);
        div_case("uFFF9_2", 1'b0, 32'hFFFFFFF9, 32'd2,
                 32'h7FFFFFFC, 32'd1, 1'b0, 0);
        div_case("u5_9", 1'b0, 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 0);
        div_case("udz", 1'b0, 32'h1234, 32'd0,
                 32'hFFFFFFFF, 32'h1234, 1'b1, 0);
        div_case("sdz", 1'b1, 32'hFFFFFFFB, 32'd0,
                 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 0);
        div_case("smin_-1", 1'b1, 32'h80000000, 32'hFFFFFFFF,
                 32'h80000000, 32'd0, 1'b0, 0);
        div_case("ignore", 1'b0, 32'd1000, 32'd9, 32'd111, 32'd1, 1'b0, 1);

        // start held high across done: second operation accepted.
        @(negedge clk);
        start     = 1'b1;
        is_signed = 1'b1;
        dividend  = 32'hFFFFFF9C;
        divisor   = 32'd7;
        @(posedge clk);
        #1;
        is_signed = 1'b0;
        dividend  = 32'hFFFFFFFF;
        divisor   = 32'h10;
        wait_done(0, n, b1, b33, bd);
        check_result("holdA", n, b1, b33, bd,
                     32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(0, n, b1, b33, bd);
        check_result("holdB", n, b1, b33, bd,
                     32'h0FFFFFFF, 32'hF, 1'b0);

        // Reset in cycle 10 aborts the division.
        @(negedge clk);
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd100;
        divisor   = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort.busy", {31'd0, busy}, 32'd0);
        chk("abort.done", {31'd0, done}, 32'd0);
        chk("abort.q", quotient, 32'd0);
        chk("abort.r", remainder, 32'd0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("abort.nodone", 32'(dcnt), 32'd0);
        div_case("after_rst", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
